ne16_column_accumulator: RTL and testbench

Downstream neighbour of the per-block binconv stage: joins the `block_pres` streams of all blocks in one array column and sums them into a single column partial result each cycle. It accumulates that sum over a configured number of iterations (weight bits × filter taps) and emits one column result on a stream. It sits between the binconv blocks of a column and the column output / normquant path.

---
 rtl/ne16_package.sv | 36 +++
 rtl/ne16_column_adder_tree.sv | 25 ++
 rtl/ne16_column_accumulator.sv | 189 ++++++++++++++++++
 tb/tb_ne16_column_accumulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ne16_package.sv
// ne16_package
// Shared types and constants for the NE16 column accumulator.
//   column_acc_state_t  : FSM state encoding (IDLE / ACCUM / OUTPUT)
//   ctrl_column_acc_t   : start, clear, nb_iter[7:0], block_mask[NE16_COLUMN_SIZE-1:0]
//   flags_column_acc_t  : state, iter_cnt[7:0], busy, overflow
//   NE16_ACC_W          : accumulator / column output width
package ne16_package;

    localparam int unsigned NE16_COLUMN_SIZE = 9;
    localparam int unsigned NE16_BLOCK_SIZE  = 16;
    localparam int unsigned NE16_QA_IN       = 8;
    localparam int unsigned NE16_QA_16BIT    = 8;
    localparam int unsigned NE16_ACC_W       = 32;
    localparam int unsigned NE16_PRES_W      = NE16_QA_IN + $clog2(NE16_BLOCK_SIZE) + NE16_QA_16BIT + 8;

    typedef enum logic [1:0] {
        CA_IDLE   = 2'd0,
        CA_ACCUM  = 2'd1,
        CA_OUTPUT = 2'd2
    } column_acc_state_t;

    typedef struct packed {
        logic                        start;
        logic                        clear;
        logic [7:0]                  nb_iter;
        logic [NE16_COLUMN_SIZE-1:0] block_mask;
    } ctrl_column_acc_t;

    typedef struct packed {
        column_acc_state_t state;
        logic [7:0]        iter_cnt;
        logic              busy;
        logic              overflow;
    } flags_column_acc_t;

endpackage

// File: rtl/ne16_column_adder_tree.sv
// ne16_column_adder_tree
// Combinational masked sum of NB unsigned block results.
//   mask_i : per-input enable; masked-out inputs contribute zero
//   data_i : NB unsigned operands of IN_W bits
//   sum_o  : OUT_W-bit sum (IN_W + clog2(NB) bits cannot overflow)
module ne16_column_adder_tree #(
    parameter int unsigned NB    = 9,
    parameter int unsigned IN_W  = 28,
    parameter int unsigned OUT_W = IN_W + $clog2(NB)
) (
    input  logic [NB-1:0]   mask_i,
    input  logic [IN_W-1:0] data_i [NB],
    output logic [OUT_W-1:0] sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (mask_i[i]) begin
                sum_o = sum_o + OUT_W'(data_i[i]);
            end
        end
    end

endmodule

// File: rtl/ne16_column_accumulator.sv
// ne16_column_accumulator
// Joins the block_pres streams of one array column, sums the masked-in
// blocks every accepted beat and accumulates nb_iter beats into one column
// result emitted on column_pres.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   test_mode_i            : clock-gate test enable
//   enable_i               : local enable, low freezes all state
//   clear_i                : synchronous clear back to IDLE
//   block_pres_*           : NB_BLOCKS sink streams (valid/data in, ready out)
//   column_pres_*          : source stream (valid/data/strb out, ready in)
//   ctrl_i / flags_o       : control and status structs
//
// Stream handshake: a transfer happens on a rising clk_i edge where valid and
// ready are both high; a producer keeps valid and data stable until that edge.
// Inputs form a join: one beat is taken only when every masked-in block is
// valid, and then all of them see ready in that same cycle.
//
// Build option NE16_COLUMN_ACC_SAT_EN: when defined the accumulator clamps to
// all-ones on overflow, otherwise it wraps. The overflow flag exists in both.
module ne16_column_accumulator
    import ne16_package::*;
#(
    parameter int unsigned NB_BLOCKS = NE16_COLUMN_SIZE,
    parameter int unsigned PRES_W    = NE16_QA_IN + $clog2(NE16_BLOCK_SIZE) + NE16_QA_16BIT + 8,
    parameter int unsigned ACC_W     = NE16_ACC_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [NB_BLOCKS-1:0] block_pres_valid_i,
    input  logic [PRES_W-1:0]    block_pres_data_i [NB_BLOCKS],
    output logic [NB_BLOCKS-1:0] block_pres_ready_o,
    output logic                 column_pres_valid_o,
    output logic [ACC_W-1:0]     column_pres_data_o,
    output logic [ACC_W/8-1:0]   column_pres_strb_o,
    input  logic                 column_pres_ready_i,
    input  ctrl_column_acc_t     ctrl_i,
    output flags_column_acc_t    flags_o
);

    localparam int unsigned SUM_W = PRES_W + $clog2(NB_BLOCKS);

    column_acc_state_t    state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [7:0]           iter_cnt_q, iter_cnt_d;
    logic [7:0]           nb_iter_q, nb_iter_d;
    logic [NB_BLOCKS-1:0] mask_q, mask_d;
    logic                 overflow_q, overflow_d;

    logic                 clear;
    logic                 data_clk_en;
    logic                 all_valid;
    logic                 accum_open;
    logic                 beat;
    logic                 last_beat;
    logic                 start_ok;
    logic                 out_hs;
    logic [SUM_W-1:0]     col_sum;
    logic [ACC_W:0]       acc_add;

    ne16_column_adder_tree #(
        .NB    (NB_BLOCKS),
        .IN_W  (PRES_W),
        .OUT_W (SUM_W)
    ) i_adder_tree (
        .mask_i (mask_q),
        .data_i (block_pres_data_i),
        .sum_o  (col_sum)
    );

    assign clear = clear_i | ctrl_i.clear;

    // Clear beats every event, so no beat, start or output handshake is
    // taken in a clearing cycle.
    assign all_valid  = &(block_pres_valid_i | ~mask_q);
    assign accum_open = (state_q == CA_ACCUM) && enable_i && !clear;
    assign beat       = accum_open && all_valid;
    assign last_beat  = beat && ((iter_cnt_q + 8'd1) == nb_iter_q);
    assign start_ok   = (state_q == CA_IDLE) && enable_i && !clear && ctrl_i.start;
    // While enable_i is low the output is frozen; a downstream ready in that
    // window does not complete a transfer.
    assign out_hs     = out_valid_q && column_pres_ready_i && enable_i && !clear;

    // Masked-out blocks are always acknowledged while accumulating so they
    // never stall; masked-in blocks only see ready together, on a join.
    assign block_pres_ready_o = accum_open ? (~mask_q | {NB_BLOCKS{all_valid}}) : '0;

    assign acc_add = {1'b0, acc_q} + (ACC_W + 1)'(col_sum);

    // FSM next state and output valid
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            CA_IDLE:   if (start_ok)  state_d = CA_ACCUM;
            CA_ACCUM:  if (last_beat) state_d = CA_OUTPUT;
            CA_OUTPUT: if (out_hs)    state_d = CA_IDLE;
            default:                  state_d = CA_IDLE;
        endcase
        if (last_beat) out_valid_d = 1'b1;
        if (out_hs)    out_valid_d = 1'b0;
        if (clear) begin
            state_d     = CA_IDLE;
            out_valid_d = 1'b0;
        end
    end

    // Datapath next state
    always_comb begin
        acc_d      = acc_q;
        iter_cnt_d = iter_cnt_q;
        nb_iter_d  = nb_iter_q;
        mask_d     = mask_q;
        overflow_d = overflow_q;
        if (start_ok) begin
            acc_d      = '0;
            iter_cnt_d = '0;
            nb_iter_d  = (ctrl_i.nb_iter == 8'd0) ? 8'd1 : ctrl_i.nb_iter;
            mask_d     = ctrl_i.block_mask;
            overflow_d = 1'b0;
        end else if (beat) begin
            iter_cnt_d = iter_cnt_q + 8'd1;
            overflow_d = overflow_q | acc_add[ACC_W];
`ifdef NE16_COLUMN_ACC_SAT_EN
            // Once clamped, any further non-zero add carries again, so the
            // value stays at all-ones without an extra saturation bit.
            acc_d = acc_add[ACC_W] ? {ACC_W{1'b1}} : acc_add[ACC_W-1:0];
`else
            acc_d = acc_add[ACC_W-1:0];
`endif
        end
        if (clear) begin
            acc_d      = '0;
            iter_cnt_d = '0;
            nb_iter_d  = '0;
            mask_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CA_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Data registers sit behind the clock gate. The gate opens on
    // enable_i|clear; test_mode_i forces it open, which is harmless because
    // the next-state logic already holds every value when not enabled.
    assign data_clk_en = enable_i | clear | test_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            iter_cnt_q <= '0;
            nb_iter_q  <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
        end else if (data_clk_en) begin
            acc_q      <= acc_d;
            iter_cnt_q <= iter_cnt_d;
            nb_iter_q  <= nb_iter_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
        end
    end

    assign column_pres_valid_o = out_valid_q;
    assign column_pres_data_o  = acc_q;
    assign column_pres_strb_o  = '1;

    always_comb begin
        flags_o          = '0;
        flags_o.state    = state_q;
        flags_o.iter_cnt = iter_cnt_q;
        flags_o.busy     = (state_q != CA_IDLE);
        flags_o.overflow = overflow_q;
    end

endmodule

// File: tb/tb_ne16_column_accumulator.sv
module tb_ne16_column_accumulator;
    import ne16_package::*;

    localparam int NB     = NE16_COLUMN_SIZE;
    localparam int PRES_W = NE16_PRES_W;
    localparam int ACC_W  = NE16_ACC_W;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              test_mode;
    logic              enable;
    logic              clear;
    logic [NB-1:0]     bvalid;
    logic [PRES_W-1:0] bdata [NB];
    logic [NB-1:0]     bready;
    logic              ovalid;
    logic [ACC_W-1:0]  odata;
    logic [ACC_W/8-1:0] ostrb;
    logic              oready;
    ctrl_column_acc_t  ctrl;
    flags_column_acc_t flags;

    ne16_column_accumulator dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .test_mode_i         (test_mode),
        .enable_i            (enable),
        .clear_i             (clear),
        .block_pres_valid_i  (bvalid),
        .block_pres_data_i   (bdata),
        .block_pres_ready_o  (bready),
        .column_pres_valid_o (ovalid),
        .column_pres_data_o  (odata),
        .column_pres_strb_o  (ostrb),
        .column_pres_ready_i (oready),
        .ctrl_i              (ctrl),
        .flags_o             (flags)
    );

    // scoreboard: {overflow, data}
    logic [ACC_W:0] exp_q[$];
    logic [ACC_W:0] mon_exp;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare every output handshake against the expected queue
    always @(negedge clk) begin
        if (rst_n && ovalid && oready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %0h expected none", odata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({flags.overflow, odata} !== mon_exp) begin
                    n_err++;
                    $display("FAIL column_result: got ovf=%0b data=%0h expected ovf=%0b data=%0h",
                             flags.overflow, odata, mon_exp[ACC_W], mon_exp[ACC_W-1:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bvalid = '0;
        for (int i = 0; i < NB; i++) bdata[i] = '0;
        ctrl   = '0;
        clear  = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] nb, input logic [NB-1:0] mask);
        ctrl.start      = 1'b1;
        ctrl.nb_iter    = nb;
        ctrl.block_mask = mask;
        cyc();
        ctrl.start = 1'b0;
    endtask

    task automatic set_all(input logic [PRES_W-1:0] v);
        bvalid = '1;
        for (int i = 0; i < NB; i++) bdata[i] = v;
    endtask

    task automatic set_ramp();
        bvalid = '1;
        for (int i = 0; i < NB; i++) bdata[i] = PRES_W'(i + 1);
    endtask

    logic [ACC_W-1:0] ovf_exp;

    initial begin
        rst_n     = 1'b1;
        test_mode = 1'b0;
        enable    = 1'b1;
        oready    = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        #10;
        check("reset_valid", ovalid, 0);
        check("reset_data", odata, 0);
        check("reset_ready", bready, 0);
        check("reset_flags", flags, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("strb_all_ones", ostrb, 4'hF);

        // all blocks, data=1, 4 beats -> 36
        exp_q.push_back({1'b0, 32'd36});
        do_start(8'd4, 9'h1FF);
        check("t1_state_accum", flags.state, CA_ACCUM);
        for (int b = 0; b < 4; b++) begin
            set_all(1);
            #1;
            check("t1_ready_join", bready, 9'h1FF);
            check("t1_no_early_valid", ovalid, 0);
            cyc();
        end
        bvalid = '0;
        check("t1_valid_after_last", ovalid, 1);
        check("t1_state_output", flags.state, CA_OUTPUT);
        check("t1_iter_cnt", flags.iter_cnt, 4);
        check("t1_busy", flags.busy, 1);
        check("t1_ready_off_output", bready, 0);
        cyc();
        check("t1_back_idle", flags.state, CA_IDLE);
        check("t1_valid_drop", ovalid, 0);

        // single block, 5+6+7 -> 18, others idle but acknowledged
        exp_q.push_back({1'b0, 32'd18});
        do_start(8'd3, 9'h001);
        #1;
        check("t2_ready_wait", bready, 9'h1FE);
        cyc();
        for (int b = 0; b < 3; b++) begin
            bvalid   = 9'h001;
            bdata[0] = PRES_W'(5 + b);
            #1;
            check("t2_ready_beat", bready, 9'h1FF);
            cyc();
        end
        bvalid = '0;
        check("t2_valid", ovalid, 1);
        cyc();

        // ramp data (sum 45/beat) x4 with a 3-cycle gap on block 4 -> 180
        exp_q.push_back({1'b0, 32'd180});
        do_start(8'd4, 9'h1FF);
        for (int b = 0; b < 2; b++) begin
            set_ramp();
            cyc();
        end
        for (int g = 0; g < 3; g++) begin
            set_ramp();
            bvalid[4] = 1'b0;
            #1;
            check("t3_gap_ready", bready, 0);
            cyc();
            check("t3_gap_iter", flags.iter_cnt, 2);
        end
        for (int b = 0; b < 2; b++) begin
            set_ramp();
            cyc();
        end
        bvalid = '0;
        check("t3_valid", ovalid, 1);
        cyc();

        // output backpressure for 5 cycles, start ignored, then restart
        exp_q.push_back({1'b0, 32'd100});
        do_start(8'd1, 9'h001);
        bvalid   = 9'h001;
        bdata[0] = PRES_W'(100);
        cyc();
        bvalid = '0;
        oready = 1'b0;
        ctrl.start      = 1'b1;
        ctrl.nb_iter    = 8'd1;
        ctrl.block_mask = 9'h001;
        for (int w = 0; w < 5; w++) begin
            #1;
            check("t4_hold_valid", ovalid, 1);
            check("t4_hold_data", odata, 100);
            check("t4_start_ignored", flags.state, CA_OUTPUT);
            cyc();
        end
        oready = 1'b1;
        cyc();
        exp_q.push_back({1'b0, 32'd7});
        check("t4_idle_after_hs", flags.state, CA_IDLE);
        cyc();
        check("t4_restart_accum", flags.state, CA_ACCUM);
        ctrl.start = 1'b0;
        bvalid     = 9'h001;
        bdata[0]   = PRES_W'(7);
        cyc();
        bvalid = '0;
        check("t4_turnaround_valid", ovalid, 1);
        cyc();

        // clear in the same cycle as the final beat
        do_start(8'd2, 9'h001);
        bvalid   = 9'h001;
        bdata[0] = PRES_W'(3);
        cyc();
        bdata[0] = PRES_W'(4);
        clear    = 1'b1;
        cyc();
        clear  = 1'b0;
        bvalid = '0;
        check("t5_state_idle", flags.state, CA_IDLE);
        check("t5_no_valid", ovalid, 0);
        check("t5_acc_zero", odata, 0);
        check("t5_flags_zero", flags, 0);
        repeat (3) cyc();
        check("t5_still_no_valid", ovalid, 0);

        // nb_iter = 0 behaves as a single beat
        exp_q.push_back({1'b0, 32'd9});
        do_start(8'd0, 9'h001);
        bvalid   = 9'h001;
        bdata[0] = PRES_W'(9);
        cyc();
        bvalid = '0;
        check("t6_one_beat_valid", ovalid, 1);
        cyc();

        // overflow: 9 * (2^28-1) = 0x8FFFFFF7 per beat, two beats carry out
`ifdef NE16_COLUMN_ACC_SAT_EN
        ovf_exp = 32'hFFFF_FFFF;
`else
        ovf_exp = 32'h1FFF_FFEE;
`endif
        exp_q.push_back({1'b1, ovf_exp});
        do_start(8'd2, 9'h1FF);
        set_all('1);
        cyc();
        check("t7_first_beat_acc", odata, 32'h8FFF_FFF7);
        check("t7_no_ovf_yet", flags.overflow, 0);
        cyc();
        bvalid = '0;
        check("t7_ovf_set", flags.overflow, 1);
        cyc();
        exp_q.push_back({1'b0, 32'd1});
        do_start(8'd1, 9'h001);
        check("t7_ovf_cleared_by_start", flags.overflow, 0);
        bvalid   = 9'h001;
        bdata[0] = PRES_W'(1);
        cyc();
        bvalid = '0;
        cyc();

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
